// File: rtl/bank_in_route_ctrl.sv
// Routes one vector of lane->bank requests into conflict-free beats: each beat
// grants, per bank, the lowest-index pending lane that targets it.
module bank_in_route_ctrl #(
  parameter int LANES = 8,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*SEL_W-1:0] in_bank,
  output logic                   out_valid,
  output logic [LANES*SEL_W-1:0] out_sel,
  output logic [LANES-1:0]       out_bank_en,
  output logic [LANES-1:0]       out_lane_grant,
  output logic                   out_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [LANES*SEL_W-1:0]   bank_q, bank_d;
  logic [LANES-1:0]         pending_q, pending_d;

  logic                     valid_q, valid_d;
  logic [LANES*SEL_W-1:0]   sel_q, sel_d;
  logic [LANES-1:0]         bank_en_q, bank_en_d;
  logic [LANES-1:0]         grant_q, grant_d;
  logic                     last_q, last_d;

  logic [LANES*SEL_W-1:0]   pick_sel;
  logic [LANES-1:0]         pick_en;
  logic [LANES-1:0]         pick_grant;
  logic [LANES-1:0]         pending_left;

  // Per-bank priority pick over the still-pending lanes. Every SEL_W code is a
  // real bank, so each non-empty pending set grants at least one lane per beat.
  // NOTE: every variable written here gets a default before the loops so no
  // path leaves it unassigned, which is what keeps this free of inferred latches.
  always_comb begin
    pick_sel   = '0;
    pick_en    = '0;
    pick_grant = '0;
    for (int b = 0; b < LANES; b++) begin
      for (int i = 0; i < LANES; i++) begin
        if (!pick_en[b] && pending_q[i] &&
            (bank_q[i*SEL_W +: SEL_W] == SEL_W'(b))) begin
          pick_sel[b*SEL_W +: SEL_W] = SEL_W'(i);
          pick_en[b]                 = 1'b1;
          pick_grant[i]              = 1'b1;
        end
      end
    end
    pending_left = pending_q & ~pick_grant;
  end

  // Next-state and registered-output logic; IDLE drives an all-zero beat.
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
    sel_d     = '0;
    bank_en_d = '0;
    grant_d   = '0;
    last_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bank_d    = in_bank;
          pending_d = '1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        valid_d   = 1'b1;
        sel_d     = pick_sel;
        bank_en_d = pick_en;
        grant_d   = pick_grant;
        pending_d = pending_left;
        last_d    = (pending_left == '0);
        if (pending_left == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; bank_q is reset too so an interrupted vector leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bank_q    <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      sel_q     <= '0;
      bank_en_q <= '0;
      grant_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      bank_en_q <= bank_en_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = valid_q;
  assign out_sel        = sel_q;
  assign out_bank_en    = bank_en_q;
  assign out_lane_grant = grant_q;
  assign out_last       = last_q;

  // Structural invariants of the beat stream.
  a_grant_matches_banks: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(out_lane_grant) == $countones(out_bank_en));

  a_last_only_when_valid: assert property (@(posedge clk) disable iff (!rst_n)
    out_last |-> out_valid);

  a_quiet_when_invalid: assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> (out_sel == '0 && out_bank_en == '0 && out_lane_grant == '0));

  a_issue_has_work: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ISSUE) |-> (pending_q != '0 && pick_grant != '0));

  a_grant_from_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ISSUE) |-> ((pick_grant & ~pending_q) == '0));

endmodule

// File: tb/tb_bank_in_route_ctrl.sv
// Scoreboard bench for bank_in_route_ctrl: directed vectors on an 8-lane and a
// 4-lane instance, expected beats queued at issue and checked by monitors.
`timescale 1ns/1ps
module tb_bank_in_route_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-lane instance
  logic        in_valid, in_ready;
  logic [23:0] in_bank;
  logic        out_valid, out_last;
  logic [23:0] out_sel;
  logic [7:0]  out_bank_en, out_lane_grant;

  // 4-lane instance
  logic        in4_valid, in4_ready;
  logic [7:0]  in4_bank;
  logic        out4_valid, out4_last;
  logic [7:0]  out4_sel;
  logic [3:0]  out4_bank_en, out4_lane_grant;

  bank_in_route_ctrl #(.LANES(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bank(in_bank),
    .out_valid(out_valid), .out_sel(out_sel), .out_bank_en(out_bank_en),
    .out_lane_grant(out_lane_grant), .out_last(out_last)
  );

  bank_in_route_ctrl #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in4_valid), .in_ready(in4_ready), .in_bank(in4_bank),
    .out_valid(out4_valid), .out_sel(out4_sel), .out_bank_en(out4_bank_en),
    .out_lane_grant(out4_lane_grant), .out_last(out4_last)
  );

  typedef struct packed {
    logic [23:0] sel;
    logic [7:0]  en;
    logic [7:0]  grant;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [7:0] sel;
    logic [3:0] en;
    logic [3:0] grant;
    logic       last;
  } beat4_t;

  beat_t  q[$];
  beat4_t q4[$];
  beat_t  mon_e;
  beat4_t mon_e4;
  int     beat_idx  = 0;
  int     beat4_idx = 0;
  int     checks    = 0;
  int     failures  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pk8(input int b0, input int b1, input int b2, input int b3,
                                      input int b4, input int b5, input int b6, input int b7);
    int          a[8];
    logic [23:0] r;
    a = '{b0, b1, b2, b3, b4, b5, b6, b7};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*3 +: 3] = a[i][2:0];
    return r;
  endfunction

  // Monitors: compare every presented beat against the head of its queue.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat8: got grant 0x%0h, expected no beat at %0t",
                 out_lane_grant, $time);
      end else begin
        mon_e = q.pop_front();
        check($sformatf("beat8[%0d].sel", beat_idx),   {8'h0, out_sel},      {8'h0, mon_e.sel});
        check($sformatf("beat8[%0d].en", beat_idx),    {24'h0, out_bank_en}, {24'h0, mon_e.en});
        check($sformatf("beat8[%0d].grant", beat_idx), {24'h0, out_lane_grant}, {24'h0, mon_e.grant});
        check($sformatf("beat8[%0d].last", beat_idx),  {31'h0, out_last},    {31'h0, mon_e.last});
        beat_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out4_valid) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat4: got grant 0x%0h, expected no beat at %0t",
                 out4_lane_grant, $time);
      end else begin
        mon_e4 = q4.pop_front();
        check($sformatf("beat4[%0d].sel", beat4_idx),   {24'h0, out4_sel},        {24'h0, mon_e4.sel});
        check($sformatf("beat4[%0d].en", beat4_idx),    {28'h0, out4_bank_en},    {28'h0, mon_e4.en});
        check($sformatf("beat4[%0d].grant", beat4_idx), {28'h0, out4_lane_grant}, {28'h0, mon_e4.grant});
        check($sformatf("beat4[%0d].last", beat4_idx),  {31'h0, out4_last},       {31'h0, mon_e4.last});
        beat4_idx++;
      end
    end
  end

  // Lanes 0..7 -> banks 7..0: one full-width beat.
  task automatic push_rev();
    beat_t e;
    e = '0;
    for (int b = 0; b < 8; b++) e.sel[b*3 +: 3] = 3'(7 - b);
    e.en    = 8'hFF;
    e.grant = 8'hFF;
    e.last  = 1'b1;
    q.push_back(e);
  endtask

  // All lanes -> bank 3: beat k grants lane k; push the first n beats.
  task automatic push_all3(input int n);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e = '0;
      e.sel[9 +: 3] = 3'(k);
      e.en          = 8'h08;
      e.grant       = 8'(1 << k);
      e.last        = (k == 7);
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [23:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    in_valid = 1'b1;
    in_bank  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d/%0d beats outstanding, expected 0", q.size(), q4.size());
    end
    @(negedge clk);
  endtask

  logic [23:0] v_rev, v_pairs, v_all3;
  beat_t       e;
  int          cyc;
  int          extra;

  initial begin
    in_valid  = 1'b0;
    in_bank   = '0;
    in4_valid = 1'b0;
    in4_bank  = '0;
    v_rev   = pk8(7, 6, 5, 4, 3, 2, 1, 0);
    v_pairs = pk8(0, 0, 1, 1, 2, 2, 3, 3);
    v_all3  = pk8(3, 3, 3, 3, 3, 3, 3, 3);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid", {31'h0, out_valid}, 32'h0);
    check("rst.out_sel", {8'h0, out_sel}, 32'h0);
    check("rst.out_bank_en", {24'h0, out_bank_en}, 32'h0);
    check("rst.out_last", {31'h0, out_last}, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", {31'h0, in_ready}, 32'h1);

    // One-beat permutation
    push_rev();
    send(v_rev);
    wait_drain();

    // Pairs per bank: two beats
    e = '0;
    e.sel = {12'h0, 3'd6, 3'd4, 3'd2, 3'd0};
    e.en = 8'h0F; e.grant = 8'h55; e.last = 1'b0;
    q.push_back(e);
    e.sel = {12'h0, 3'd7, 3'd5, 3'd3, 3'd1};
    e.en = 8'h0F; e.grant = 8'hAA; e.last = 1'b1;
    q.push_back(e);
    send(v_pairs);
    wait_drain();
    check("idle.out_valid", {31'h0, out_valid}, 32'h0);
    check("idle.out_lane_grant", {24'h0, out_lane_grant}, 32'h0);
    check("idle.in_ready", {31'h0, in_ready}, 32'h1);

    // Eight-beat conflict with in_valid held and in_bank churning,
    // next vector accepted in the out_last cycle.
    push_all3(8);
    push_rev();
    @(negedge clk);
    in_valid = 1'b1;
    in_bank  = v_all3;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy.in_ready", {31'h0, in_ready}, 32'h0);
      if (in_ready) break;
      in_bank = 24'($urandom);
    end
    check("busy.accept_cycle", cyc, 9);
    check("busy.last_visible", {31'h0, out_last}, 32'h1);
    in_bank = v_rev;
    @(negedge clk);
    in_valid = 1'b0;
    check("gap.out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("next.out_valid", {31'h0, out_valid}, 32'h1);
    wait_drain();

    // 4-lane: {2,2,2,1}
    e = '0;
    q4.push_back('{sel: 8'h0C, en: 4'h6, grant: 4'h9, last: 1'b0});
    q4.push_back('{sel: 8'h10, en: 4'h4, grant: 4'h2, last: 1'b0});
    q4.push_back('{sel: 8'h20, en: 4'h4, grant: 4'h4, last: 1'b1});
    @(negedge clk);
    in4_valid = 1'b1;
    in4_bank  = 8'h6A;
    @(negedge clk);
    in4_valid = 1'b0;
    wait_drain();

    // Reset pulsed during beat 3 of the all-bank-3 vector
    push_all3(4);
    @(negedge clk);
    in_valid = 1'b1;
    in_bank  = v_all3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.out_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst.out_sel", {8'h0, out_sel}, 32'h0);
    check("async_rst.out_bank_en", {24'h0, out_bank_en}, 32'h0);
    check("async_rst.out_lane_grant", {24'h0, out_lane_grant}, 32'h0);
    check("async_rst.out_last", {31'h0, out_last}, 32'h0);
    check("async_rst.beats_before", q.size(), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst.in_ready", {31'h0, in_ready}, 32'h1);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("post_rst.stale_beats", extra, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
